// File: rtl/fila_pkg.sv
// Shared types and helpers for the fila_param queue.
// Optional watermark output is enabled with FILA_WATERMARK_EN.
package fila_pkg;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } fila_state_t;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_LIFO = 1'b1
  } fila_mode_t;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [31:0] fila_ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    logic [31:0] nxt;
    if (ptr == depth - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fila_param_if.sv
// Bus bundle between producer/consumer logic and the fila_param queue.
// almost_full exists only when FILA_WATERMARK_EN is defined.
interface fila_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             enqueue_in;
  logic             dequeue_in;
  logic             mode_lifo;
  logic             clear_err;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [LW-1:0]    len_out;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
`ifdef FILA_WATERMARK_EN
  logic             almost_full;
`endif

  modport master (
    output data_in, enqueue_in, dequeue_in, mode_lifo, clear_err,
`ifdef FILA_WATERMARK_EN
    input  almost_full,
`endif
    input  data_out, data_valid, len_out, full, empty, overflow, underflow
  );

  modport slave (
    input  data_in, enqueue_in, dequeue_in, mode_lifo, clear_err,
`ifdef FILA_WATERMARK_EN
    output almost_full,
`endif
    output data_out, data_valid, len_out, full, empty, overflow, underflow
  );

endinterface

// File: rtl/fila_param_edge_rise.sv
// Rising-edge detector: one cycle pulse when d goes from 0 to 1.
module edge_rise (
  input  logic clock_10KHz,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic d_q_r;

  // Previous-cycle sample of the request line.
  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      d_q_r <= 1'b0;
    end else begin
      d_q_r <= d;
    end
  end

  assign rise = d & ~d_q_r;
endmodule

// File: rtl/fila_param.sv
// Parametrised FIFO/LIFO buffer with edge-triggered commands and sticky errors.
// Define FILA_WATERMARK_EN to add AF_LEVEL and the almost_full output.
module fila_param
  import fila_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
`ifdef FILA_WATERMARK_EN
  , parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic         clock_10KHz,
  input  logic         reset,
  fila_param_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] data_out_r;
  logic             data_valid_r;
  logic [LW-1:0]    len_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  fila_state_t      state_r;
  fila_mode_t       mode_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             enq_s;
  logic             deq_s;
  logic             is_empty_s;
  logic             is_full_s;
  logic             lifo_s;
  logic             wr_en_s;
  logic [PW-1:0]    wr_idx_s;
  logic [PW-1:0]    rd_idx_s;
  logic [PW-1:0]    head_inc_s;
  logic [PW-1:0]    tail_inc_s;
  logic [LW-1:0]    len_nxt_s;

  edge_rise u_enq_edge (.clock_10KHz(clock_10KHz), .reset(reset), .d(bus.enqueue_in), .rise(enq_s));
  edge_rise u_deq_edge (.clock_10KHz(clock_10KHz), .reset(reset), .d(bus.dequeue_in), .rise(deq_s));

  // Operation decode: storage addressing, write enable and next element count.
  always_comb begin
    is_empty_s = (state_r == S_EMPTY);
    is_full_s  = (state_r == S_FULL);
    lifo_s     = (mode_r == MODE_LIFO);
    head_inc_s = PW'(fila_ptr_inc(32'(head_r), 32'(DEPTH)));
    tail_inc_s = PW'(fila_ptr_inc(32'(tail_r), 32'(DEPTH)));
    // The stack pointer is the element count itself.
    rd_idx_s   = lifo_s ? PW'(len_r - LW'(1)) : head_r;
    wr_idx_s   = lifo_s ? PW'(len_r) : tail_r;
    wr_en_s    = 1'b0;
    len_nxt_s  = len_r;
    if (enq_s && deq_s) begin
      wr_en_s = !is_empty_s && !lifo_s;
    end else if (enq_s) begin
      wr_en_s = !is_full_s;
      if (!is_full_s) begin
        len_nxt_s = len_r + LW'(1);
      end else begin
        len_nxt_s = len_r;
      end
    end else if (deq_s) begin
      if (!is_empty_s) begin
        len_nxt_s = len_r - LW'(1);
      end else begin
        len_nxt_s = len_r;
      end
    end else begin
      len_nxt_s = len_r;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clock_10KHz) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= bus.data_in;
    end
  end

  // Control FSM, pointers, output data and sticky error flags.
  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      state_r      <= S_EMPTY;
      mode_r       <= MODE_FIFO;
      head_r       <= '0;
      tail_r       <= '0;
      len_r        <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      len_r        <= len_nxt_s;
      overflow_r   <= (enq_s & ~deq_s & is_full_s) | (overflow_r & ~bus.clear_err);
      underflow_r  <= (deq_s & ~enq_s & is_empty_s) | (underflow_r & ~bus.clear_err);
      if (is_empty_s && !enq_s) begin
        mode_r <= fila_mode_t'(bus.mode_lifo);
      end else begin
        mode_r <= mode_r;
      end
      if (enq_s && deq_s) begin
        data_valid_r <= 1'b1;
        if (!is_empty_s && !lifo_s) begin
          data_out_r <= mem_r[head_r];
          head_r     <= head_inc_s;
          tail_r     <= tail_inc_s;
        end else begin
          data_out_r <= bus.data_in;
        end
      end else if (enq_s) begin
        if (!is_full_s && !lifo_s) begin
          tail_r <= tail_inc_s;
        end else begin
          tail_r <= tail_r;
        end
        case (state_r)
          S_EMPTY:   state_r <= S_PARTIAL;
          S_PARTIAL: state_r <= (len_r == LW'(DEPTH - 1)) ? S_FULL : S_PARTIAL;
          default:   state_r <= state_r;
        endcase
      end else if (deq_s) begin
        if (!is_empty_s) begin
          data_out_r   <= mem_r[rd_idx_s];
          data_valid_r <= 1'b1;
          if (!lifo_s) begin
            head_r <= head_inc_s;
          end else begin
            head_r <= head_r;
          end
        end else begin
          data_out_r <= data_out_r;
        end
        case (state_r)
          S_PARTIAL: state_r <= (len_r == LW'(1)) ? S_EMPTY : S_PARTIAL;
          S_FULL:    state_r <= S_PARTIAL;
          default:   state_r <= state_r;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

`ifdef FILA_WATERMARK_EN
  logic almost_full_r;

  // Watermark tracks the same next count that len_out loads.
  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      almost_full_r <= 1'b0;
    end else begin
      almost_full_r <= (32'(len_nxt_s) >= $unsigned(AF_LEVEL));
    end
  end

  assign bus.almost_full = almost_full_r;
`endif

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.len_out    = len_r;
  assign bus.full       = is_full_s;
  assign bus.empty      = is_empty_s;
  assign bus.overflow   = overflow_r;
  assign bus.underflow  = underflow_r;
endmodule

// File: tb/tb_fila_param.sv
// Scoreboard bench for fila_param: queue-based reference model, directed plus random stimulus.
module tb_fila_param;
  localparam int W = 8;
  localparam int D = 8;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] len;
    logic       ovf;
    logic       unf;
  } stat_t;

  logic clk;
  logic rst_n;

  fila_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fila_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clock_10KHz(clk),
    .reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  stat_t      sq[$];
  logic [7:0] dq[$];

  // Reference model state
  logic [7:0] mq[$];
  bit         m_lifo;
  bit         pe, pd;
  bit         m_ovf, m_unf;
  logic [7:0] m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_lifo = 1'b0;
    pe = 1'b0;
    pd = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_out = 8'h00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
    chk({tag, "_valid"}, 32'(bus.data_valid), 32'h0);
    chk({tag, "_len"}, 32'(bus.len_out), 32'h0);
    chk({tag, "_full"}, 32'(bus.full), 32'h0);
    chk({tag, "_empty"}, 32'(bus.empty), 32'h1);
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'h0);
    chk({tag, "_unf"}, 32'(bus.underflow), 32'h0);
  endtask

  // One cycle of stimulus; the model predicts the outcome of the next edge.
  task automatic step(input bit e, input bit d, input logic [7:0] din, input bit ml, input bit clr);
    bit ev_e, ev_d, v, nov, nun, cap;
    stat_t s;
    @(negedge clk);
    bus.enqueue_in = e;
    bus.dequeue_in = d;
    bus.data_in    = din;
    bus.mode_lifo  = ml;
    bus.clear_err  = clr;
    ev_e = e & ~pe;
    ev_d = d & ~pd;
    pe = e;
    pd = d;
    v = 1'b0;
    nov = 1'b0;
    nun = 1'b0;
    cap = (mq.size() == 0) && !ev_e;
    if (ev_e && ev_d) begin
      v = 1'b1;
      if (mq.size() != 0 && !m_lifo) begin
        m_out = mq.pop_front();
        mq.push_back(din);
      end else begin
        m_out = din;
      end
    end else if (ev_e) begin
      if (mq.size() == D) nov = 1'b1;
      else mq.push_back(din);
    end else if (ev_d) begin
      if (mq.size() == 0) begin
        nun = 1'b1;
      end else begin
        v = 1'b1;
        m_out = m_lifo ? mq.pop_back() : mq.pop_front();
      end
    end
    m_ovf = nov | (m_ovf & ~clr);
    m_unf = nun | (m_unf & ~clr);
    if (cap) m_lifo = ml;
    if (v) dq.push_back(m_out);
    s.v = v;
    s.d = m_out;
    s.len = 4'(mq.size());
    s.ovf = m_ovf;
    s.unf = m_unf;
    sq.push_back(s);
  endtask

  task automatic pulse_enq(input logic [7:0] din, input bit ml);
    step(1'b1, 1'b0, din, ml, 1'b0);
    step(1'b0, 1'b0, 8'h00, ml, 1'b0);
  endtask

  task automatic pulse_deq(input bit ml);
    step(1'b0, 1'b1, 8'h00, ml, 1'b0);
    step(1'b0, 1'b0, 8'h00, ml, 1'b0);
  endtask

  // Monitor: compares every predicted cycle and every data_valid strobe.
  initial begin
    stat_t s;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("valid", 32'(bus.data_valid), 32'(s.v));
        chk("data_out", 32'(bus.data_out), 32'(s.d));
        chk("len_out", 32'(bus.len_out), 32'(s.len));
        chk("full", 32'(bus.full), 32'(s.len == 4'd8));
        chk("empty", 32'(bus.empty), 32'(s.len == 4'd0));
        chk("overflow", 32'(bus.overflow), 32'(s.ovf));
        chk("underflow", 32'(bus.underflow), 32'(s.unf));
      end
      if (bus.data_valid === 1'b1) begin
        if (dq.size() > 0) begin
          e = dq.pop_front();
          chk("deq_data", 32'(bus.data_out), 32'(e));
        end else begin
          chk("unexpected_valid", 32'(bus.data_valid), 32'h0);
        end
      end
    end
  end

  initial begin
    bus.enqueue_in = 1'b0;
    bus.dequeue_in = 1'b0;
    bus.data_in    = 8'h00;
    bus.mode_lifo  = 1'b0;
    bus.clear_err  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic FIFO order
    pulse_enq(8'h11, 1'b0);
    pulse_enq(8'h22, 1'b0);
    pulse_enq(8'h33, 1'b0);
    repeat (3) pulse_deq(1'b0);

    // Fill, overflow, clear, drain, underflow
    for (int i = 1; i <= 8; i++) pulse_enq(8'(i), 1'b0);
    pulse_enq(8'hFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (9) pulse_deq(1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // LIFO with mode toggle while non-empty
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    pulse_enq(8'hA1, 1'b1);
    pulse_enq(8'hA2, 1'b1);
    pulse_enq(8'hA3, 1'b1);
    pulse_deq(1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    pulse_deq(1'b0);
    pulse_deq(1'b0);

    // Held request produces one enqueue
    repeat (5) step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    pulse_deq(1'b0);

    // Simultaneous events: empty pass-through, then FIFO swap
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    pulse_enq(8'h10, 1'b0);
    pulse_enq(8'h20, 1'b0);
    step(1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    pulse_deq(1'b0);
    pulse_deq(1'b0);

    // Asynchronous reset with five entries stored
    for (int i = 0; i < 5; i++) pulse_enq(8'(8'hC0 + i), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    bus.enqueue_in = 1'b0;
    bus.dequeue_in = 1'b0;
    bus.clear_err  = 1'b0;
    bus.mode_lifo  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic in both modes
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
           8'($urandom),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    chk("stat_queue_drained", 32'(sq.size()), 32'h0);
    chk("data_queue_drained", 32'(dq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fila_param.md
Name: fila_param

Overview:
- Parametrised successor of the 8x8 queue: configurable data width and depth, with runtime FIFO/LIFO mode.
- Adds rising-edge command detection, same-cycle enqueue+dequeue, full/empty flags, a dequeue-valid strobe and sticky overflow/underflow error flags.
- Sits between the 10 kHz producer/consumer logic and display/consumer stages as the standard buffering container.

Parameters:
WIDTH, 8, data bits per entry (>=1)
DEPTH, 8, number of entries (>=2, need not be a power of two)

Ports:
clock_10KHz  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
data_in  in  WIDTH  data to store
enqueue_in  in  1  enqueue request; acts on rising edge only
dequeue_in  in  1  dequeue request; acts on rising edge only
mode_lifo  in  1  0 = FIFO, 1 = LIFO; latched only while empty
clear_err  in  1  level; clears sticky error flags
data_out  out  WIDTH  last dequeued value (registered)
data_valid  out  1  one-cycle strobe: data_out updated by a dequeue
len_out  out  $clog2(DEPTH+1)  current element count
full  out  1  len_out == DEPTH
empty  out  1  len_out == 0
overflow  out  1  sticky: enqueue attempted while full
underflow  out  1  sticky: dequeue attempted while empty

Behaviour:
- Reset (reset=0, async): data_out=0, data_valid=0, len_out=0, full=0, empty=1, overflow=0, underflow=0.
  - Pointers=0, mode=FIFO, state=S_EMPTY, edge registers=0.
  - Storage contents are not cleared.
  - Reset mid-operation aborts the operation and discards contents.
- Edge detection:
  - enq_ev = enqueue_in & ~enqueue_q; deq_ev likewise.
  - Holding a request high yields exactly one operation.
- Latency:
  - An event sampled at edge N is applied at edge N.
  - data_out, data_valid, len_out and the flags reflect it after edge N (visible in cycle N+1).
- FSM states: S_EMPTY, S_PARTIAL, S_FULL. The state is registered; full/empty decode from it.
  - S_EMPTY -> S_PARTIAL on enq only.
  - S_PARTIAL -> S_FULL on enq only when len_out == DEPTH-1.
  - S_PARTIAL -> S_EMPTY on deq only when len_out == 1.
  - S_FULL -> S_PARTIAL on deq only.
  - Both events together never change state.
- FIFO mode:
  - Write at tail, read at head.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, not modulo.
- LIFO mode:
  - Single stack pointer `sp` (= len_out).
  - Enqueue writes mem[sp]; dequeue reads mem[sp-1].
- Mode latch:
  - mode_lifo is captured every cycle while in S_EMPTY with no enq_ev.
  - It is ignored otherwise.
- Enqueue only:
  - Not full: store data_in, len_out+1.
  - Full: no store, set overflow; len_out and contents unchanged.
- Dequeue only:
  - Not empty: data_out <= selected entry, data_valid=1, len_out-1.
  - Empty: data_out keeps its value, data_valid=0, set underflow.
- Simultaneous enq_ev and deq_ev:
  - Empty: pass-through. data_out <= data_in, data_valid=1, len_out stays 0, no error.
  - FIFO, not empty (including full): data_out <= mem[head] and mem[tail] <= data_in. Both pointers advance; len_out unchanged.
  - LIFO, not empty: pass-through. data_out <= data_in, data_valid=1, stack unchanged.
- data_valid is 0 in any cycle without a successful dequeue.
- clear_err=1 clears overflow/underflow. A new error in the same cycle wins, so the flag stays set.
- All arithmetic is unsigned. len_out never exceeds DEPTH or goes below 0.

Optional Feature:
FILA_WATERMARK_EN:
- Defined:
  - Adds parameter AF_LEVEL (default DEPTH-2).
  - Adds output almost_full = (len_out >= AF_LEVEL), registered alongside len_out; reset value 0.
- Undefined: no parameter, no port; the rest of the behaviour is identical.

Decomposition:
- fila_pkg:
  - typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} fila_state_t.
  - typedef enum logic {MODE_FIFO, MODE_LIFO} fila_mode_t.
  - Function fila_ptr_inc(ptr, depth) for explicit wrap.
- Sub-module edge_rise:
  - One flop plus AND.
  - Clock_10KHz and active-low async reset.
  - Instantiated twice, for enqueue_in and dequeue_in.

Test Plan:
- Reset, FIFO, WIDTH=8, DEPTH=8:
  - Stimulus: enqueue 0x11,0x22,0x33 as 1-cycle pulses, then 3 dequeues.
  - Required: data_out 0x11,0x22,0x33, each with one data_valid pulse the cycle after its edge; len_out 3->0, empty=1.
- Wrap/full, FIFO:
  - Stimulus: 8 enqueues 0x01..0x08, 9th enqueue 0xFF.
  - Required: full=1, overflow=1, len_out=8.
  - Then 8 dequeues return 0x01..0x08 with no 0xFF; a 9th dequeue sets underflow=1, data_out stays 0x08, data_valid=0.
- LIFO, mode_lifo=1 while empty:
  - Stimulus: enqueue 0xA1,0xA2,0xA3, then 3 dequeues.
  - Required: data_out 0xA3,0xA2,0xA1.
  - Toggling mode_lifo to 0 with len_out=2 has no effect on order.
- Held request: enqueue_in high 5 cycles with data_in=0x5A -> len_out increments by exactly 1.
- Simultaneous events:
  - Both pulsed while empty: data_out=data_in, len_out=0, no error.
  - FIFO with contents {0x10,0x20}, both pulsed with data_in=0x30: data_out=0x10, len_out=2, later dequeues give 0x20,0x30.
- Async reset asserted mid-sequence with len_out=5 -> all outputs at reset values immediately, before the next clock edge.
- clear_err after overflow -> flag drops the next cycle.
